ks10_run_ctl: RTL
=================

# ks10_run_ctl

Run/halt sequencer that drives the KS10 core's control inputs: `clken`, `run`, `execute`, `msec_en` and `d`. It sits between the console/front-end command path and the KS10 core. It produces the core clock-enable and the 1 ms timebase, and turns console commands (halt, run, single-step, execute-word) into correctly timed core control levels and pulses. It also provides a watchdog on execute completion.

## Interface
- `CLKDIV`, default 1: `clken` period in `clk` cycles (≥1).
- `MSEC_COUNT`, default 50000: `clk` cycles per `msec_en` pulse (1 ms at 50 MHz).
- `TIMEOUT_MS`, default 10: ms allowed for an execute to reach core halt.

Ports:
- `clk`  in  1: system clock; one clock domain.
- `rst`  in  1: reset, asynchronous, active-high.
- `cmd_valid`  in  1: console command valid.
- `cmd_ready`  out  1: command accepted when `cmd_valid & cmd_ready`.
- `cmd_op`  in  2: 00 halt, 01 run, 10 step, 11 execute.
- `cmd_data`  in  36: instruction word for execute.
- `core_halt`  in  1: core reports halted state (level).
- `clken`  out  1: core clock enable.
- `msec_en`  out  1: one-cycle 1 ms tick.
- `run`  out  1: core run level.
- `execute`  out  1: core execute strobe.
- `d`  out  36: execute data to core.
- `state`  out  2: 00 HALTED, 01 RUNNING, 10 STEP, 11 EXEC.
- `err`  out  1: sticky execute-timeout flag.

## Operation
- Reset values: `state`=HALTED, `cmd_ready`=1, `clken`=0, `msec_en`=0, `run`=0, `execute`=0, `d`=0, `err`=0. All counters are cleared. Asserting `rst` mid-operation aborts any command immediately.
- Clock-enable divider: the counter runs 0..CLKDIV-1 and `clken`=1 in the cycle where counter==CLKDIV-1. With CLKDIV=1, `clken` is 1 in every cycle after reset release.
- Millisecond timebase: the counter runs 0..MSEC_COUNT-1 independent of `clken`. `msec_en` is high for one cycle at terminal count.
- HALTED (`cmd_ready`=1):
  - run → RUNNING, `run`=1.
  - step → STEP.
  - execute → `d`<=`cmd_data`, EXEC.
  - halt → consumed, no effect.
- RUNNING (`cmd_ready`=1):
  - halt cmd, or `core_halt`=1 → `run`=0, HALTED. Both in the same cycle give the same result.
  - run, step and execute commands are consumed and ignored.
- STEP (`cmd_ready`=0): `run`=1 for exactly one `clken`-qualified cycle, i.e. from the next cycle with `clken`=1 through that cycle. Then `run`=0 and HALTED.
- EXEC (`cmd_ready`=0):
  - `execute`=1 for exactly one `clken`-qualified cycle. `d` holds its value until the next execute command.
  - After the strobe, wait for `core_halt`=1 → HALTED.
  - The ms timeout counter clears on EXEC entry and increments on `msec_en`. When it reaches TIMEOUT_MS, set `err`=1 and go to HALTED.
  - `err` clears only on `rst` or on acceptance of the next execute command.
- `core_halt` is ignored in HALTED and STEP, and ignored in EXEC until the strobe has been issued.
- `run` and `execute` are never high simultaneously.

## Timing
- All outputs are registered. A command accepted at edge N changes `state` and `cmd_ready` at edge N+1.
- Run from HALTED: `run` is high from edge N+1.
- Halt in RUNNING: `run` is low from edge N+1. `core_halt` sampled high at edge N drops `run` at edge N+1.
- Step/exec pulse latency: the pulse occupies the first cycle after entry in which `clken`=1.
  - CLKDIV=1: the pulse is in cycle N+1 and HALTED (or wait) follows at N+2.
  - Worst case CLKDIV cycles of extra delay.
- `cmd_ready` returns high the cycle after re-entering HALTED.
- `msec_en`: first pulse MSEC_COUNT cycles after reset release, then period MSEC_COUNT.
- Timeout: `err` rises between TIMEOUT_MS-1 and TIMEOUT_MS ms after EXEC entry, in the cycle after the qualifying `msec_en`.

## Test plan
- Reset (rst high 91 ns, 20 ns clk, CLKDIV=1) → all outputs at reset values, then `clken`=1 every cycle. With MSEC_COUNT=50, `msec_en` pulses every 50 cycles.
- Run then halt cmd → `run` high from the cycle after acceptance, low one cycle after the halt is accepted, `state` 01→00. Repeat with `core_halt` instead of the halt cmd, and with both in the same cycle → identical result.
- Step with CLKDIV=4 → `run` high for exactly one cycle, coincident with `clken`. `cmd_ready`=0 throughout; `state`=HALTED afterwards.
- Execute `cmd_data`=36'o254000001000, with `core_halt` raised 20 cycles later → `d`=36'o254000001000, `execute` is a single one-cycle pulse, `err`=0, HALTED.
- Execute with `core_halt` held 0, MSEC_COUNT=50, TIMEOUT_MS=3 → `err`=1 after about 150 cycles, HALTED. The next execute clears `err`.
- Assert `rst` during STEP and during EXEC → `run`/`execute` drop immediately (asynchronously), `state`=HALTED, `d`=0.

Source files
------------

// File: rtl/ks10_run_ctl.sv
// KS10 run/halt sequencer: core clock-enable, 1 ms timebase, and console command
// sequencing (halt/run/step/execute) with an execute-completion watchdog.
module ks10_run_ctl #(
    parameter int unsigned CLKDIV     = 1,
    parameter int unsigned MSEC_COUNT = 50000,
    parameter int unsigned TIMEOUT_MS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [35:0] cmd_data,
    input  logic        core_halt,
    output logic        clken,
    output logic        msec_en,
    output logic        run,
    output logic        execute,
    output logic [35:0] d,
    output logic [1:0]  state,
    output logic        err
);

    localparam int unsigned DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int unsigned MS_W  = (MSEC_COUNT > 1) ? $clog2(MSEC_COUNT) : 1;
    localparam int unsigned TMO_W = (TIMEOUT_MS > 0) ? $clog2(TIMEOUT_MS + 1) : 1;

    localparam logic [1:0] OP_HALT = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_EXEC = 2'b11;

    typedef enum logic [1:0] {
        S_HALTED  = 2'b00,
        S_RUNNING = 2'b01,
        S_STEP    = 2'b10,
        S_EXEC    = 2'b11
    } state_e;

    state_e             state_q;
    logic               cmd_ready_q;
    logic               run_q;
    logic               execute_q;
    logic [35:0]        d_q;
    logic               err_q;
    logic               pulsed_q;
    logic [TMO_W-1:0]   tmo_q;
    logic [DIV_W-1:0]   div_q;
    logic [DIV_W-1:0]   div_d;
    logic               clken_q;
    logic               clken_d;
    logic [MS_W-1:0]    ms_q;
    logic [MS_W-1:0]    ms_d;
    logic               msec_en_q;
    logic               msec_en_d;
    logic               cmd_fire_c;
    logic               tmo_hit_c;

    // Free-running divider and ms counters; the _d values predict next cycle's strobes.
    always_comb begin
        clken_d    = (div_q == DIV_W'(CLKDIV - 1));
        div_d      = clken_d ? '0 : div_q + DIV_W'(1);
        msec_en_d  = (ms_q == MS_W'(MSEC_COUNT - 1));
        ms_d       = msec_en_d ? '0 : ms_q + MS_W'(1);
        cmd_fire_c = cmd_valid & cmd_ready_q;
        tmo_hit_c  = msec_en_q & (tmo_q == TMO_W'(TIMEOUT_MS - 1));
    end

    // Sequencer: step/exec pulses are launched on the edge that also raises clken,
    // so the pulse lands exactly in the next clken-qualified cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_HALTED;
            cmd_ready_q <= 1'b1;
            run_q       <= 1'b0;
            execute_q   <= 1'b0;
            d_q         <= '0;
            err_q       <= 1'b0;
            pulsed_q    <= 1'b0;
            tmo_q       <= '0;
            div_q       <= '0;
            clken_q     <= 1'b0;
            ms_q        <= '0;
            msec_en_q   <= 1'b0;
        end else begin
            div_q     <= div_d;
            clken_q   <= clken_d;
            ms_q      <= ms_d;
            msec_en_q <= msec_en_d;

            unique case (state_q)
                S_HALTED: begin
                    if (cmd_fire_c) begin
                        unique case (cmd_op)
                            OP_RUN: begin
                                state_q <= S_RUNNING;
                                run_q   <= 1'b1;
                            end
                            OP_STEP: begin
                                state_q     <= S_STEP;
                                cmd_ready_q <= 1'b0;
                                run_q       <= clken_d;
                                pulsed_q    <= clken_d;
                            end
                            OP_EXEC: begin
                                state_q     <= S_EXEC;
                                cmd_ready_q <= 1'b0;
                                d_q         <= cmd_data;
                                err_q       <= 1'b0;
                                tmo_q       <= '0;
                                execute_q   <= clken_d;
                                pulsed_q    <= clken_d;
                            end
                            default: ;
                        endcase
                    end
                end
                S_RUNNING: begin
                    if ((cmd_fire_c && (cmd_op == OP_HALT)) || core_halt) begin
                        state_q <= S_HALTED;
                        run_q   <= 1'b0;
                    end
                end
                S_STEP: begin
                    if (pulsed_q) begin
                        state_q     <= S_HALTED;
                        cmd_ready_q <= 1'b1;
                        run_q       <= 1'b0;
                        pulsed_q    <= 1'b0;
                    end else if (clken_d) begin
                        run_q    <= 1'b1;
                        pulsed_q <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (msec_en_q) begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                    if (pulsed_q) begin
                        execute_q <= 1'b0;
                    end else if (clken_d) begin
                        execute_q <= 1'b1;
                        pulsed_q  <= 1'b1;
                    end
                    // Completion wins over a coincident timeout.
                    if ((pulsed_q && core_halt) || tmo_hit_c) begin
                        state_q     <= S_HALTED;
                        cmd_ready_q <= 1'b1;
                        execute_q   <= 1'b0;
                        pulsed_q    <= 1'b0;
                        if (!(pulsed_q && core_halt)) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_HALTED;
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign clken     = clken_q;
    assign msec_en   = msec_en_q;
    assign run       = run_q;
    assign execute   = execute_q;
    assign d         = d_q;
    assign state     = state_q;
    assign err       = err_q;

endmodule
